// File: rtl/v_resv_tracker_pkg.sv
// Shared types and timing defaults for the vector reservation tracker.
// Counters are 8 bits so that the longest reservation, 64+16 cycles, fits.
package v_resv_tracker_pkg;

  localparam int NREG = 8;
  localparam int CW   = 8;

  localparam int READ_LAT_D     = 2;
  localparam int WRITE_LAT_D    = 1;
  localparam int CHAIN_WINDOW_D = 1;
  localparam int FU_EXTRA_D     = 1;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_LEAD,
    S_WR_CHAIN,
    S_WR_DRAIN
  } resv_state_e;

  function automatic cnt_t max_cnt(cnt_t a, cnt_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/v_reg_resv.sv
// Reservation FSM for one vector register: rem_q counts the busy cycles
// left, ph_q counts the cycles left in the lead or chain phase.
module v_reg_resv
  import v_resv_tracker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_start_i,
  input  logic rd_start_i,
  input  cnt_t wr_len_i,
  input  cnt_t rd_len_i,
  input  cnt_t lead_i,
  input  cnt_t chl_i,
  output logic busy_o,
  output logic chain_n_o
);

  resv_state_e state_q, state_d;
  cnt_t        rem_q, rem_d;
  cnt_t        ph_q, ph_d;
  cnt_t        chl_q, chl_d;
  logic        chaining;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ph_d     = ph_q;
    chl_d    = chl_q;
    chaining = (state_q == S_WR_LEAD) ||
               (state_q == S_WR_CHAIN);

    if (state_q != S_IDLE) begin
      rem_d = rem_q - 8'd1;
      if (rem_q == 8'd1) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_WR_LEAD: begin
            if (ph_q == 8'd1) begin
              state_d = S_WR_CHAIN;
              ph_d    = chl_q;
            end else begin
              ph_d = ph_q - 8'd1;
            end
          end
          S_WR_CHAIN: begin
            if (ph_q == 8'd1) state_d = S_WR_DRAIN;
            else              ph_d = ph_q - 8'd1;
          end
          default: ;
        endcase
      end
    end

    if (wr_start_i) begin
      rem_d = rd_start_i ? max_cnt(wr_len_i, rd_len_i)
                         : wr_len_i;
      chl_d = chl_i;
      if (lead_i != '0) begin
        state_d = S_WR_LEAD;
        ph_d    = lead_i;
      end else begin
        state_d = S_WR_CHAIN;
        ph_d    = chl_i;
      end
    end else if (rd_start_i && chaining) begin
      // chained operand: keep the write path, stretch busy
      if (rd_len_i > rem_d) begin
        rem_d = rd_len_i;
        if (state_d == S_IDLE) state_d = S_WR_DRAIN;
      end
    end else if (rd_start_i) begin
      state_d = S_RD;
      rem_d   = rd_len_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ph_q    <= '0;
      chl_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ph_q    <= ph_d;
      chl_q   <= chl_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign chain_n_o = (state_q != S_WR_CHAIN);

endmodule

// File: rtl/v_resv_tracker.sv
// Vector register and FU reservation tracker feeding v_scheduler's
// busy/chain inputs, one cycle behind issue.
module v_resv_tracker
  import v_resv_tracker_pkg::*;
#(
  parameter int LOGDEPTH     = 6,
  parameter int READ_LAT     = READ_LAT_D,
  parameter int WRITE_LAT    = WRITE_LAT_D,
  parameter int CHAIN_WINDOW = CHAIN_WINDOW_D,
  parameter int FU_EXTRA     = FU_EXTRA_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_v_issue,
  input  logic [NREG-1:0]     i_vwrite_start,
  input  logic [NREG-1:0]     i_vread_start,
  input  logic [NREG-1:0]     i_vfu_start,
  input  logic [3:0]          i_fu_delay,
  input  logic [LOGDEPTH:0]   i_vl,
  output logic [NREG-1:0]     o_vreg_busy,
  output logic [NREG-1:0]     o_vreg_chain_n,
  output logic [NREG-1:0]     o_vfu_busy,
  output logic                o_any_busy
);

  cnt_t            l_eff, f_lat;
  cnt_t            wr_len, rd_len;
  cnt_t            lead, chl, fu_len;
  logic [NREG-1:0] wr_go, rd_go, fu_go;
  cnt_t            fu_q [NREG];
  cnt_t            fu_d [NREG];

  always_comb begin
    l_eff  = (i_vl == '0) ? cnt_t'(1 << LOGDEPTH)
                          : cnt_t'(i_vl);
    f_lat  = cnt_t'(i_fu_delay) + cnt_t'(WRITE_LAT);
    wr_len = f_lat + l_eff - 8'd1;
    rd_len = l_eff + cnt_t'(READ_LAT);
    lead   = f_lat - 8'd1;
    fu_len = l_eff + cnt_t'(FU_EXTRA);
    // chain window never outlives the write itself
    chl    = (l_eff < cnt_t'(CHAIN_WINDOW)) ? l_eff
                                            : cnt_t'(CHAIN_WINDOW);
    wr_go  = i_vwrite_start & {NREG{i_v_issue}};
    rd_go  = i_vread_start  & {NREG{i_v_issue}};
    fu_go  = i_vfu_start    & {NREG{i_v_issue}};
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    v_reg_resv u_reg (
      .clk       (clk),
      .rst       (rst),
      .wr_start_i(wr_go[g]),
      .rd_start_i(rd_go[g]),
      .wr_len_i  (wr_len),
      .rd_len_i  (rd_len),
      .lead_i    (lead),
      .chl_i     (chl),
      .busy_o    (o_vreg_busy[g]),
      .chain_n_o (o_vreg_chain_n[g])
    );
  end

  always_comb begin
    for (int n = 0; n < NREG; n++) begin
      if (fu_go[n])            fu_d[n] = fu_len;
      else if (fu_q[n] != '0)  fu_d[n] = fu_q[n] - 8'd1;
      else                     fu_d[n] = '0;
      o_vfu_busy[n] = (fu_q[n] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) fu_q[n] <= '0;
    end else begin
      for (int n = 0; n < NREG; n++) fu_q[n] <= fu_d[n];
    end
  end

  assign o_any_busy = (|o_vreg_busy) | (|o_vfu_busy);

endmodule
